// File: rtl/conv_encoder_stream.sv
// Streaming rate-1/2 convolutional encoder with valid/ready on both sides
// and optional zero-tail termination back to state 0.
module conv_encoder_stream #(
  parameter int          K         = 3,
  parameter int unsigned G0        = 'b111,
  parameter int unsigned G1        = 'b101,
  parameter bit          TERMINATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_last,
  output logic       busy
);

  localparam int CW = $clog2(K);
  localparam logic [K-1:0] G0_M = G0[K-1:0];
  localparam logic [K-1:0] G1_M = G1[K-1:0];

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [K-1:1]  sr, sr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic         load;
  logic         accept;
  logic         step;
  logic         cur;
  logic         last_tail;
  logic [K-1:0] win;
  logic [1:0]   sym;

  assign load      = !out_valid || out_ready;
  assign in_ready  = load && (state != FLUSH);
  assign accept    = in_valid && in_ready;
  assign step      = load && (state == FLUSH);
  assign cur       = accept ? in_bit : 1'b0;
  assign win       = {sr, cur};
  assign sym       = {^(win & G1_M), ^(win & G0_M)};
  assign last_tail = (cnt == CW'(1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    unique case (1'b1)
      accept: begin
        sr_nxt = {sr[K-2:1], in_bit};
        if (!in_last) begin
          state_nxt = RUN;
        end else if (TERMINATE) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(K-1);
        end else begin
          state_nxt = IDLE;
          sr_nxt    = '0;
        end
      end
      step: begin
        // tail bits are zeros, so the register drains toward state 0
        sr_nxt  = {sr[K-2:1], 1'b0};
        cnt_nxt = cnt - CW'(1);
        if (last_tail) begin
          sr_nxt    = '0;
          state_nxt = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        out_valid <= accept || step;
        if (accept || step) begin
          out_sym  <= sym;
          out_last <= accept ? (in_last && !TERMINATE) : last_tail;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Directed and randomised checks of conv_encoder_stream in three
// configurations: default, K=7 impulse response, and no tail.
module tb_conv_encoder_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [3];
  logic       ib   [3];
  logic       il   [3];
  logic       ordy [3];
  logic       ir   [3];
  logic       ov   [3];
  logic [1:0] os   [3];
  logic       ol   [3];
  logic       bz   [3];

  int checks = 0;
  int errors = 0;

  logic       src  [$];
  logic       srcl [$];
  logic [1:0] refq [$];
  logic       refl [$];

  always #5 clk = ~clk;

  conv_encoder_stream u0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_bit(ib[0]), .in_last(il[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sym(os[0]),
    .out_last(ol[0]), .busy(bz[0])
  );

  conv_encoder_stream #(
    .K(7), .G0('b1111001), .G1('b1011011), .TERMINATE(1'b1)
  ) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_bit(ib[1]), .in_last(il[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sym(os[1]),
    .out_last(ol[1]), .busy(bz[1])
  );

  conv_encoder_stream #(
    .K(3), .G0('b111), .G1('b101), .TERMINATE(1'b0)
  ) u2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_bit(ib[2]), .in_last(il[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sym(os[2]),
    .out_last(ol[2]), .busy(bz[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: full rate, 1: out_ready 1,0,0 pattern, 2: random handshakes
  task automatic run_frame(input int d, input int mode, input string tag);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [1:0] held = 2'b00;
    logic held_l = 1'b0;
    while (got < refq.size() && cyc < 3000) begin
      case (mode)
        0: ordy[d] = 1'b1;
        1: ordy[d] = (cyc % 3 == 0);
        default: ordy[d] = 1'($urandom_range(0, 1));
      endcase
      iv[d] = (sent < src.size()) &&
              (mode != 2 || $urandom_range(0, 3) != 0);
      ib[d] = (sent < src.size()) ? src[sent] : 1'b0;
      il[d] = (sent < src.size()) ? srcl[sent] : 1'b0;
      #1;
      if (stalled) begin
        chk({tag, "_hold_v"}, 32'(ov[d]), 32'd1);
        chk({tag, "_hold_sym"}, 32'(os[d]), 32'(held));
        chk({tag, "_hold_last"}, 32'(ol[d]), 32'(held_l));
      end
      stalled = ov[d] && !ordy[d];
      if (stalled) begin
        chk({tag, "_stall_ir"}, 32'(ir[d]), 32'd0);
        held = os[d];
        held_l = ol[d];
      end
      if (ov[d] && ordy[d]) begin
        chk({tag, "_sym"}, 32'(os[d]), 32'(refq[got]));
        chk({tag, "_last"}, 32'(ol[d]), 32'(refl[got]));
        got++;
      end
      if (iv[d] && ir[d]) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_count"}, 32'(got), 32'(refq.size()));
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    #1;
    chk({tag, "_drained"}, 32'(ov[d]), 32'd0);
    chk({tag, "_idle"}, 32'(bz[d]), 32'd0);
  endtask

  initial begin
    logic [2:0] h;
    logic b;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ib[i] = 1'b0; il[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_out_sym", 32'(os[0]), 32'd0);
    chk("rst_out_last", 32'(ol[0]), 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd1);

    src = '{1, 0, 1, 1};
    srcl = '{0, 0, 0, 1};
    refq = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
    refl = '{0, 0, 0, 0, 0, 1};
    run_frame(0, 0, "dflt");
    chk("dflt_sr_zero", 32'(u0.sr), 32'd0);
    run_frame(0, 1, "stall");

    src = '{1};
    srcl = '{1};
    refq = '{2'd3, 2'd2, 2'd0, 2'd3, 2'd3, 2'd1, 2'd3};
    refl = '{0, 0, 0, 0, 0, 0, 1};
    run_frame(1, 0, "k7");

    src = '{1, 1, 1};
    srcl = '{0, 1, 1};
    refq = '{2'd3, 2'd2, 2'd3};
    refl = '{0, 1, 1};
    run_frame(2, 0, "notail");

    iv[0] = 1'b1; ib[0] = 1'b1; il[0] = 1'b0;
    @(posedge clk);
    #1;
    ib[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(bz[0]), 32'd1);
    chk("abort_pending", 32'(ov[0]), 32'd1);
    iv[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_valid", 32'(ov[0]), 32'd0);
    chk("abort_last", 32'(ol[0]), 32'd0);
    chk("abort_busy_clr", 32'(bz[0]), 32'd0);
    chk("abort_in_ready", 32'(ir[0]), 32'd1);
    src = '{1};
    srcl = '{1};
    refq = '{2'd3, 2'd1, 2'd3};
    refl = '{0, 0, 1};
    run_frame(0, 0, "after_abort");

    for (int f = 0; f < 100; f++) begin
      src = {};
      srcl = {};
      refq = {};
      refl = {};
      h = 3'b000;
      for (int i = 0; i < 34; i++) begin
        b = (i < 32) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (i < 32) begin
          src.push_back(b);
          srcl.push_back(i == 31);
        end
        h = {h[1:0], b};
        refq.push_back({^(h & 3'b101), ^(h & 3'b111)});
        refl.push_back(i == 33);
      end
      run_frame(0, 2, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
